// File: rtl/cosim_pkg.sv
// Shared types for the co-simulation commit sequencer.
// Record layout, record kinds and sequencer states.
package cosim_pkg;

   localparam int XLEN      = 64;
   localparam int INST_LEN  = 32;
   localparam int CW_DEF    = 3;
   localparam int DEPTH_DEF = 16;

   typedef enum logic {
      REC_COMMIT = 1'b0,
      REC_TRAP   = 1'b1
   } rec_kind_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_ERR   = 2'd2
   } seq_state_e;

   typedef struct packed {
      rec_kind_e           kind;
      logic [XLEN-1:0]     pc;
      logic [INST_LEN-1:0] inst;
      logic [XLEN-1:0]     wdata;
      logic [XLEN-1:0]     mstatus;
      logic                check;
      logic [XLEN-1:0]     cause;
   } cosim_rec_t;

   function automatic cosim_rec_t trap_rec(
      input logic [XLEN-1:0] cause
   );
      cosim_rec_t r;
      r       = '0;
      r.kind  = REC_TRAP;
      r.cause = cause;
      return r;
   endfunction

endpackage

// File: rtl/cosim_lane_compactor.sv
// Packs the valid retire lanes into consecutive slots, lowest lane first.
// Ports: i_valid lane mask; o_sel lane per slot; o_slot_vld; o_n_commit count.
module cosim_lane_compactor #(
   parameter int CW = 3,
   parameter int LW = 2,
   parameter int NW = 5
) (
   input  logic [CW-1:0]         i_valid,
   output logic [CW-1:0][LW-1:0] o_sel,
   output logic [CW-1:0]         o_slot_vld,
   output logic [NW-1:0]         o_n_commit
);

   logic [NW-1:0] w_cnt;

   always_comb begin
      o_sel      = '0;
      o_slot_vld = '0;
      w_cnt      = '0;
      for (int i = 0; i < CW; i++) begin
         // slot k takes lane i when i is valid and k lanes below it are valid
         for (int k = 0; k < CW; k++) begin
            if (i_valid[i] && (w_cnt == NW'(k))) begin
               o_sel[k]      = LW'(i);
               o_slot_vld[k] = 1'b1;
            end
         end
         w_cnt = w_cnt + NW'(i_valid[i]);
      end
      o_n_commit = w_cnt;
   end

endmodule

// File: rtl/cosim_commit_sequencer.sv
// Serialises multi-lane commits plus traps into a single-lane checker stream.
// Ports: in_* bundle from core, out_* head record to checker, ovf_err, occupancy.
module cosim_commit_sequencer
   import cosim_pkg::*;
#(
   parameter int COMMIT_WIDTH = CW_DEF,
   parameter int DEPTH        = DEPTH_DEF
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [COMMIT_WIDTH-1:0]      in_valid,
   input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
   input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
   input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
   input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
   input  logic [COMMIT_WIDTH-1:0]      in_check,
   input  logic                         in_int_xcpt,
   input  logic [XLEN-1:0]              in_cause,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [XLEN-1:0]              out_pc,
   output logic [INST_LEN-1:0]          out_inst,
   output logic [XLEN-1:0]              out_wdata,
   output logic [XLEN-1:0]              out_mstatus,
   output logic                         out_check,
   output logic                         out_int_xcpt,
   output logic [XLEN-1:0]              out_cause,
   input  logic                         out_ready,
   output logic                         ovf_err,
   output logic [$clog2(DEPTH):0]       occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

   cosim_rec_t r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_occ;
   logic          r_in_ready;
   seq_state_e    r_state;
   seq_state_e    w_state_nxt;

   cosim_rec_t                     w_lane_rec [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0][LW-1:0] w_sel;
   logic [COMMIT_WIDTH-1:0]        w_slot_vld;
   logic [COMMIT_WIDTH-1:0][AW-1:0] w_wr_idx;
   logic [PW-1:0] w_n_commit;
   logic [PW-1:0] w_n_enq;
   logic [PW-1:0] w_occ_nxt;
   logic [PW-1:0] w_trap_ptr;
   logic          w_any;
   logic          w_accept;
   logic          w_ovf;
   logic          w_empty;
   logic          w_deq;
   logic          w_ready_nxt;
   cosim_rec_t    w_head;

   cosim_lane_compactor #(
      .CW (COMMIT_WIDTH),
      .LW (LW),
      .NW (PW)
   ) u_compact (
      .i_valid    (in_valid),
      .o_sel      (w_sel),
      .o_slot_vld (w_slot_vld),
      .o_n_commit (w_n_commit)
   );

   always_comb begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_lane_rec[i]         = '0;
         w_lane_rec[i].kind    = REC_COMMIT;
         w_lane_rec[i].pc      = in_pc[i*XLEN +: XLEN];
         w_lane_rec[i].inst    = in_inst[i*INST_LEN +: INST_LEN];
         w_lane_rec[i].wdata   = in_wdata[i*XLEN +: XLEN];
         w_lane_rec[i].mstatus = in_mstatus[i*XLEN +: XLEN];
         w_lane_rec[i].check   = in_check[i];
      end
   end

   always_comb begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         w_wr_idx[k] = AW'(r_wr_ptr + PW'(k));
      end
   end

   assign w_any      = (|in_valid) | in_int_xcpt;
   assign w_accept   = r_in_ready & w_any;
   assign w_ovf      = ~r_in_ready & w_any;
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_deq      = ~w_empty & out_ready;
   assign w_n_enq    = w_accept ? (w_n_commit + PW'(in_int_xcpt)) : '0;
   assign w_occ_nxt  = r_occ + w_n_enq - PW'(w_deq);
   assign w_trap_ptr = r_wr_ptr + w_n_commit;
   assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

   // Room for one worst-case bundle after this cycle's update.
   assign w_ready_nxt =
      ((DEPTH - int'(w_occ_nxt)) >= (COMMIT_WIDTH + 1));

   always_ff @(posedge clock) begin
      if (w_accept && !reset) begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (w_slot_vld[k]) begin
               r_mem[w_wr_idx[k]] <= w_lane_rec[w_sel[k]];
            end
         end
         if (in_int_xcpt) begin
            r_mem[w_trap_ptr[AW-1:0]] <= trap_rec(in_cause);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_in_ready <= 1'b1;
         r_state    <= ST_RUN;
      end else begin
         r_wr_ptr   <= r_wr_ptr + w_n_enq;
         r_rd_ptr   <= r_rd_ptr + PW'(w_deq);
         r_occ      <= w_occ_nxt;
         r_in_ready <= w_ready_nxt;
         r_state    <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_RUN: begin
            if (!w_empty && !out_ready) w_state_nxt = ST_STALL;
         end
         ST_STALL: begin
            if (out_ready) w_state_nxt = ST_RUN;
         end
         ST_ERR: begin
            w_state_nxt = ST_ERR;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
      if (w_ovf) w_state_nxt = ST_ERR;
   end

   assign out_valid    = ~w_empty & (w_head.kind == REC_COMMIT);
   assign out_int_xcpt = ~w_empty & (w_head.kind == REC_TRAP);
   assign out_pc       = w_empty ? '0 : w_head.pc;
   assign out_inst     = w_empty ? '0 : w_head.inst;
   assign out_wdata    = w_empty ? '0 : w_head.wdata;
   assign out_mstatus  = w_empty ? '0 : w_head.mstatus;
   assign out_check    = ~w_empty & w_head.check;
   assign out_cause    = w_empty ? '0 : w_head.cause;
   assign in_ready     = r_in_ready;
   assign ovf_err      = (r_state == ST_ERR);
   assign occupancy    = r_occ;

endmodule
